// File: rtl/gshare_pkg.sv
// Shared opcode constants and FSM state type for the gshare branch predictor family.
package gshare_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

endpackage

// File: rtl/sat_counter_upd.sv
// Combinational saturating increment/decrement of a CTR_BITS-wide prediction counter.
module sat_counter_upd #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                inc,
    output logic [CTR_BITS-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc && (ctr != '1)) begin
            ctr_next = ctr + CTR_BITS'(1);
        end else if (!inc && (ctr != '0)) begin
            ctr_next = ctr - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// Gshare branch predictor with speculative GHR, mispredict recovery and hardware table init.
// Optional GSHARE_BP_STATS_EN adds resolved-branch and mispredict counters.
module gshare_bp
    import gshare_pkg::*;
#(
    parameter int IDX_BITS = 8,
    parameter int GHR_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int PC_BITS  = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                pred_valid,
    input  logic [PC_BITS-1:0]  pred_pc,
    input  logic [6:0]          pred_opcode,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [PC_BITS-1:0]  upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic                upd_mispredict
`ifdef GSHARE_BP_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

    state_t              state, state_next;
    logic [IDX_BITS-1:0] init_ptr;
    logic [GHR_BITS-1:0] ghr, ghr_next;
    logic [CTR_BITS-1:0] tbl [2**IDX_BITS];

    logic [IDX_BITS-1:0] pidx, uidx;
    logic [CTR_BITS-1:0] upd_cur, upd_next;
    logic                run, spec_shift, recover;
    logic [GHR_BITS:0]   shift_cat, recover_cat;

    assign run  = (state == RUN);
    assign pidx = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
    assign uidx = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_ghr);

    assign ready    = run;
    assign pred_ghr = run ? ghr : '0;
    assign upd_cur  = tbl[uidx];

    sat_counter_upd #(
        .CTR_BITS(CTR_BITS)
    ) u_sat (
        .ctr     (upd_cur),
        .inc     (upd_taken),
        .ctr_next(upd_next)
    );

    always_comb begin
        pred_taken = 1'b0;
        if (run) begin
            case (pred_opcode)
                OPC_JAL, OPC_JALR: pred_taken = 1'b1;
                OPC_BRANCH:        pred_taken = tbl[pidx][CTR_BITS-1];
                default:           pred_taken = 1'b0;
            endcase
        end
    end

    // Concatenate-then-truncate keeps the shift legal when GHR_BITS is 1.
    assign shift_cat   = {ghr, pred_taken};
    assign recover_cat = {upd_ghr, upd_taken};
    assign spec_shift  = run && pred_valid && (pred_opcode == OPC_BRANCH);
    assign recover     = run && upd_valid && upd_mispredict;

    always_comb begin
        ghr_next = ghr;
        if (recover) begin
            ghr_next = recover_cat[GHR_BITS-1:0];
        end else if (spec_shift) begin
            ghr_next = shift_cat[GHR_BITS-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (init_ptr == '1) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_ptr <= '0;
            ghr      <= '0;
        end else begin
            state <= state_next;
            ghr   <= ghr_next;
            if (state == INIT) begin
                init_ptr <= init_ptr + IDX_BITS'(1);
            end
        end
    end

    // Table contents are not reset; the INIT sweep establishes them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                tbl[init_ptr] <= WNT;
            end else if (upd_valid) begin
                tbl[uidx] <= upd_next;
            end
        end
    end

`ifdef GSHARE_BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (run && upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (upd_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[PC_BITS-1:IDX_BITS+2], pred_pc[1:0],
                              upd_pc[PC_BITS-1:IDX_BITS+2], upd_pc[1:0]};

endmodule

// File: tb/tb_gshare_bp.sv
// Directed self-checking bench for gshare_bp (default parameters: 256 entries, 8-bit GHR, 2-bit counters).
module tb_gshare_bp;
    import gshare_pkg::*;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic [6:0]  pred_opcode;
    logic        pred_taken;
    logic [7:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;
`ifdef GSHARE_BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_br   = 0;
    int exp_mis  = 0;

    localparam logic [6:0] OPC_ALU = 7'b0110011;

    gshare_bp dut (
        .clk           (clk),
        .rst           (rst),
        .ready         (ready),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_opcode   (pred_opcode),
        .pred_taken    (pred_taken),
        .pred_ghr      (pred_ghr),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_ghr       (upd_ghr),
        .upd_taken     (upd_taken),
        .upd_mispredict(upd_mispredict)
`ifdef GSHARE_BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1ns after an edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic [6:0] opc,
                                 input logic uv, input logic [31:0] upc, input logic [7:0] ughr,
                                 input logic ut, input logic um);
        pred_valid     = pv;
        pred_pc        = pc;
        pred_opcode    = opc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_ghr        = ughr;
        upd_taken      = ut;
        upd_mispredict = um;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update(input logic [31:0] pc, input logic [7:0] ughr, input logic t, input logic m);
        applyStimulus(1'b0, 32'h0, 7'h0, 1'b1, pc, ughr, t, m);
        tick();
        exp_br++;
        if (m) exp_mis++;
    endtask

    // Branch prediction probe paired with a recovery that restores GHR to zero.
    task automatic probe(input string tag, input logic [31:0] pc, input logic exp);
        applyStimulus(1'b1, pc, OPC_BRANCH, 1'b1, 32'h3FC, 8'h00, 1'b0, 1'b1);
        checkOutput(tag, 32'(pred_taken), 32'(exp));
        checkOutput({tag, "_ghr"}, 32'(pred_ghr), 32'h0);
        tick();
        exp_br++;
        exp_mis++;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("reset_ready", 32'(ready), 32'h0);
        rst = 1'b0;

        // Traffic during INIT must be ignored entirely.
        applyStimulus(1'b1, 32'h0, OPC_BRANCH, 1'b1, 32'h0, 8'hFF, 1'b1, 1'b1);
        repeat (100) tick();
        checkOutput("mid_init_ready", 32'(ready), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            checkOutput("init_ready", 32'(ready), 32'h0);
            checkOutput("init_taken", 32'(pred_taken), 32'h0);
            checkOutput("init_ghr", 32'(pred_ghr), 32'h0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        checkOutput("run_ready", 32'(ready), 32'h1);
        checkOutput("run_ghr", 32'(pred_ghr), 32'h0);

        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 32'(i << 2), OPC_BRANCH, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
            checkOutput("sweep_wnt", 32'(pred_taken), 32'h0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        checkOutput("sweep_ghr", 32'(pred_ghr), 32'h0);

        // Entry 0x10: 01 -> 10 -> 11 -> 11 -> 10 -> 01
        update(32'h40, 8'h00, 1'b1, 1'b0);
        probe("ctr_10", 32'h40, 1'b1);
        update(32'h40, 8'h00, 1'b1, 1'b0);
        probe("ctr_11", 32'h40, 1'b1);
        update(32'h40, 8'h00, 1'b1, 1'b0);
        update(32'h40, 8'h00, 1'b0, 1'b0);
        probe("ctr_sat_10", 32'h40, 1'b1);
        update(32'h40, 8'h00, 1'b0, 1'b0);
        probe("ctr_back_01", 32'h40, 1'b0);

        // Train 0x20, 0x21, 0x23 so pc 0x80 predicts taken under GHR 0, 1, 3.
        update(32'h80, 8'h00, 1'b1, 1'b0);
        update(32'h84, 8'h00, 1'b1, 1'b0);
        update(32'h8C, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h80, OPC_BRANCH, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        checkOutput("spec1_taken", 32'(pred_taken), 32'h1);
        checkOutput("spec1_ghr", 32'(pred_ghr), 32'h0);
        tick();
        checkOutput("spec2_taken", 32'(pred_taken), 32'h1);
        checkOutput("spec2_ghr", 32'(pred_ghr), 32'h1);
        tick();
        checkOutput("spec3_taken", 32'(pred_taken), 32'h1);
        checkOutput("spec3_ghr", 32'(pred_ghr), 32'h3);
        tick();
        applyStimulus(1'b1, 32'h80, OPC_BRANCH, 1'b1, 32'h3FC, 8'h00, 1'b0, 1'b1);
        checkOutput("spec_ghr_111", 32'(pred_ghr), 32'h7);
        checkOutput("idx27_taken", 32'(pred_taken), 32'h0);
        tick();
        exp_br++;
        exp_mis++;
        applyStimulus(1'b1, 32'h200, OPC_ALU, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        checkOutput("recover_beats_spec", 32'(pred_ghr), 32'h0);
        checkOutput("alu_taken", 32'(pred_taken), 32'h0);
        tick();

        update(32'h3FC, 8'h05, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 32'h3FC, 8'h55, 1'b1, 1'b1);
        checkOutput("recover_taken", 32'(pred_ghr), 32'h0B);
        tick();
        checkOutput("mispredict_no_valid", 32'(pred_ghr), 32'h0B);
        update(32'h3FC, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        checkOutput("recover_zero", 32'(pred_ghr), 32'h0);

        applyStimulus(1'b1, 32'h100, OPC_JAL, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        checkOutput("jal_taken", 32'(pred_taken), 32'h1);
        tick();
        applyStimulus(1'b1, 32'h104, OPC_JALR, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        checkOutput("jalr_taken", 32'(pred_taken), 32'h1);
        checkOutput("jal_ghr_same", 32'(pred_ghr), 32'h0);
        tick();
        applyStimulus(1'b1, 32'h108, OPC_ALU, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        checkOutput("other_taken", 32'(pred_taken), 32'h0);
        checkOutput("jalr_ghr_same", 32'(pred_ghr), 32'h0);
        tick();

        applyStimulus(1'b1, 32'h40, OPC_BRANCH, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
        checkOutput("same_cycle_old", 32'(pred_taken), 32'h0);
        tick();
        exp_br++;
        probe("same_cycle_new", 32'h40, 1'b1);

`ifdef GSHARE_BP_STATS_EN
        checkOutput("stat_branches", stat_branches, 32'(exp_br));
        checkOutput("stat_mispredicts", stat_mispredicts, 32'(exp_mis));
`endif

        applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
